// File: rtl/rv_lsu_pkg.sv
// Shared definitions for the RV32 data-memory load/store unit:
// funct3 encodings, FSM state type and the load-extension helper.
package rv_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Wide enough for the largest legal LATENCY of 8.
    localparam int CNT_W = $clog2(8) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESP
    } lsu_state_t;

    // Select the byte/half addressed by ofs and extend it to 32 bits.
    function automatic logic [31:0] load_ext(input logic [2:0]  funct3,
                                             input logic [1:0]  ofs,
                                             input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{ofs, 3'b000} +: 8];
        h = ofs[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    load_ext = {{24{b[7]}}, b};
            F3_BU:   load_ext = {24'h0, b};
            F3_H:    load_ext = {{16{h[15]}}, h};
            F3_HU:   load_ext = {16'h0, h};
            default: load_ext = word;
        endcase
    endfunction

endpackage

// File: rtl/dmem_ram_be.sv
// Single-port DEPTH_WORDS x 32 RAM with per-byte write enables,
// synchronous write and registered read, written to stay RAM-inferable.
module dmem_ram_be #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [3:0]    be,
    input  logic          re,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    // NOTE: the array and its read register have no reset; clearing a RAM
    // is not a single-cycle operation and would block RAM inference.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
        if (re) rdata <= mem[addr];
    end

endmodule

// File: rtl/dmem_lsu.sv
// RV32 load/store front end for the data RAM: valid/ready request,
// configurable latency, alignment/range checking and a one-cycle response.
module dmem_lsu
    import rv_lsu_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          LATENCY     = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);

    lsu_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept, go_resp;

    logic             we_q, err_q;
    logic [2:0]       f3_q;
    logic [1:0]       ofs_q;
    logic [AW-1:0]    idx_q;
    logic [3:0]       be_q;
    logic [31:0]      wd_q;
    logic [31:0]      hold_rdata_q;
    logic             hold_err_q;

    logic [31:0]      off;
    logic             req_err;
    logic [3:0]       req_be;
    logic [31:0]      req_wd;
    logic [31:0]      ram_rdata;
    logic [31:0]      live_rdata;

    // BASE_ADDR is aligned to the array size, so off[1:0] equals req_addr[1:0].
    assign off = req_addr - BASE_ADDR;

    always_comb begin
        req_err = (off[31:AW+2] != '0);
        req_be  = 4'b1111;
        req_wd  = req_wdata;
        case (req_funct3)
            F3_B: begin
                req_be = 4'b0001 << off[1:0];
                req_wd = {4{req_wdata[7:0]}};
            end
            F3_H: begin
                if (off[0]) req_err = 1'b1;
                req_be = off[1] ? 4'b1100 : 4'b0011;
                req_wd = {2{req_wdata[15:0]}};
            end
            F3_W:    if (off[1:0] != 2'b00) req_err = 1'b1;
            F3_BU:   if (req_we) req_err = 1'b1;
            F3_HU:   if (req_we || off[0]) req_err = 1'b1;
            default: req_err = 1'b1;
        endcase
    end

    // NOTE: every signal assigned here gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY <= 1) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_BUSY;
                        cnt_d   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            ST_BUSY: begin
                if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
                if (cnt_q <= CNT_W'(1)) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With LATENCY=1 the RAM access shares the accept edge, so it must use
    // the live request rather than the not-yet-loaded latches.
    assign go_resp = (state_d == ST_RESP) && (state_q != ST_RESP);

    logic          cur_we, cur_err;
    logic [AW-1:0] cur_idx;
    logic [3:0]    cur_be;
    logic [31:0]   cur_wd;

    assign cur_we  = accept ? req_we        : we_q;
    assign cur_err = accept ? req_err       : err_q;
    assign cur_idx = accept ? off[AW+1:2]   : idx_q;
    assign cur_be  = accept ? req_be        : be_q;
    assign cur_wd  = accept ? req_wd        : wd_q;

    dmem_ram_be #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .AW         (AW)
    ) u_ram (
        .clk  (clk),
        .we   (go_resp && cur_we && !cur_err),
        .be   (cur_be),
        .re   (go_resp && !cur_we && !cur_err),
        .addr (cur_idx),
        .wdata(cur_wd),
        .rdata(ram_rdata)
    );

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            err_q        <= 1'b0;
            f3_q         <= 3'b000;
            ofs_q        <= 2'b00;
            idx_q        <= '0;
            be_q         <= 4'b0000;
            wd_q         <= 32'h0;
            hold_rdata_q <= 32'h0;
            hold_err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                we_q  <= req_we;
                err_q <= req_err;
                f3_q  <= req_funct3;
                ofs_q <= off[1:0];
                idx_q <= off[AW+1:2];
                be_q  <= req_be;
                wd_q  <= req_wd;
            end
            if (state_q == ST_RESP) begin
                hold_rdata_q <= live_rdata;
                hold_err_q   <= err_q;
            end
        end
    end

    assign live_rdata = (err_q || we_q) ? 32'h0 : load_ext(f3_q, ofs_q, ram_rdata);

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_rdata = rsp_valid ? live_rdata : hold_rdata_q;
    assign rsp_err   = rsp_valid ? err_q      : hold_err_q;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: instance 0 runs with LATENCY=1,
// instance 1 with LATENCY=4; expected values are hand-computed constants.
module tb_dmem_lsu;
    import rv_lsu_pkg::*;

    logic             clk;
    logic [1:0]       rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_we;
    logic [1:0][2:0]  req_funct3;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       req_ready;
    logic [1:0]       rsp_valid;
    logic [1:0][31:0] rsp_rdata;
    logic [1:0]       rsp_err;

    int n_assert = 0;
    int n_fail   = 0;

    dmem_lsu #(.DEPTH_WORDS(256), .LATENCY(1), .BASE_ADDR(32'h0)) u_l1 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dmem_lsu #(.DEPTH_WORDS(256), .LATENCY(4), .BASE_ADDR(32'h0)) u_l4 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request on instance d (called at a negedge while idle),
    // then check latency, response data/error, pulse width and data hold.
    task automatic xact(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd, input string tag,
                        input logic [31:0] exp_rd, input logic exp_err);
        int lat;
        int exp_lat;
        exp_lat       = (d == 0) ? 1 : 4;
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = a;
        req_wdata[d]  = wd;
        check({tag, "_ready"}, req_ready[d], 1'b1);
        @(negedge clk);
        req_valid[d] = 1'b0;
        lat = 1;
        while (!rsp_valid[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_rdata"}, rsp_rdata[d], exp_rd);
        check({tag, "_err"}, rsp_err[d], exp_err);
        @(negedge clk);
        check({tag, "_pulse"}, rsp_valid[d], 1'b0);
        check({tag, "_hold"}, rsp_rdata[d], exp_rd);
    endtask

    initial begin
        int lat;
        rst_n      = 2'b00;
        req_valid  = '0;
        req_we     = '0;
        req_funct3 = '0;
        req_addr   = '0;
        req_wdata  = '0;
        repeat (2) @(negedge clk);
        rst_n = 2'b11;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check("rst_ready", req_ready[d], 1'b1);
            check("rst_valid", rsp_valid[d], 1'b0);
            check("rst_rdata", rsp_rdata[d], 32'h0);
            check("rst_err", rsp_err[d], 1'b0);
        end

        // Word store/load round trip
        xact(0, 1'b1, F3_W, 32'h10, 32'hDEADBEEF, "sw10", 32'h0, 1'b0);
        xact(0, 1'b0, F3_W, 32'h10, 32'h0, "lw10", 32'hDEADBEEF, 1'b0);

        // Sub-word loads with sign/zero extension
        xact(0, 1'b0, F3_B,  32'h13, 32'h0, "lb13",  32'hFFFFFFDE, 1'b0);
        xact(0, 1'b0, F3_BU, 32'h13, 32'h0, "lbu13", 32'h000000DE, 1'b0);
        xact(0, 1'b0, F3_H,  32'h10, 32'h0, "lh10",  32'hFFFFBEEF, 1'b0);
        xact(0, 1'b0, F3_HU, 32'h12, 32'h0, "lhu12", 32'h0000DEAD, 1'b0);
        xact(0, 1'b0, F3_B,  32'h10, 32'h0, "lb10",  32'hFFFFFFEF, 1'b0);

        // Byte store touches only its lane
        xact(0, 1'b1, F3_B, 32'h11, 32'h000000AA, "sb11", 32'h0, 1'b0);
        xact(0, 1'b0, F3_W, 32'h10, 32'h0, "lw10_sb", 32'hDEADAAEF, 1'b0);

        // Error cases; stores alias onto word 0x10 if not suppressed
        xact(0, 1'b0, F3_W,   32'h12,  32'h0,        "lw12_mis", 32'h0, 1'b1);
        xact(0, 1'b1, F3_H,   32'h13,  32'h00001111, "sh13_mis", 32'h0, 1'b1);
        xact(0, 1'b0, 3'b011, 32'h10,  32'h0,        "f3_011",   32'h0, 1'b1);
        xact(0, 1'b0, F3_W,   32'h400, 32'h0,        "lw_oor",   32'h0, 1'b1);
        xact(0, 1'b1, F3_W,   32'h410, 32'h0,        "sw_oor",   32'h0, 1'b1);
        xact(0, 1'b1, F3_BU,  32'h10,  32'h00000055, "sbu_ill",  32'h0, 1'b1);
        xact(0, 1'b0, F3_W,   32'h10,  32'h0,        "lw10_err", 32'hDEADAAEF, 1'b0);

        // Halfword store into upper lane
        xact(0, 1'b1, F3_H,  32'h12, 32'hFFFF1234, "sh12", 32'h0, 1'b0);
        xact(0, 1'b0, F3_W,  32'h10, 32'h0, "lw10_sh", 32'h1234AAEF, 1'b0);

        // LATENCY=4: requests held during BUSY are ignored until IDLE
        xact(1, 1'b1, F3_W, 32'h24, 32'h55667788, "l4_sw24", 32'h0, 1'b0);
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b1;
        req_funct3[1] = F3_W;
        req_addr[1]   = 32'h20;
        req_wdata[1]  = 32'h11223344;
        @(negedge clk);
        req_we[1]   = 1'b0;
        req_addr[1] = 32'h24;
        for (int n = 1; n <= 5; n++) begin
            check("hold_ready", req_ready[1], n == 5);
            check("hold_rspv", rsp_valid[1], n == 4);
            if (n == 4) begin
                check("hold_sw_rdata", rsp_rdata[1], 32'h0);
                check("hold_sw_err", rsp_err[1], 1'b0);
            end
            if (n < 5) @(negedge clk);
        end
        @(negedge clk);
        req_valid[1] = 1'b0;
        lat = 1;
        while (!rsp_valid[1] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        check("hold_lw_lat", lat, 4);
        check("hold_lw_rdata", rsp_rdata[1], 32'h55667788);
        @(negedge clk);
        xact(1, 1'b0, F3_W, 32'h20, 32'h0, "l4_lw20", 32'h11223344, 1'b0);

        // Reset two cycles into a LATENCY=4 store aborts it
        req_valid[1]  = 1'b1;
        req_we[1]     = 1'b1;
        req_funct3[1] = F3_W;
        req_addr[1]   = 32'h20;
        req_wdata[1]  = 32'h12345678;
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst_n[1] = 1'b0;
        #1;
        check("abort_ready", req_ready[1], 1'b1);
        check("abort_rspv", rsp_valid[1], 1'b0);
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            check("abort_no_rsp", rsp_valid[1], 1'b0);
        end
        xact(1, 1'b0, F3_W, 32'h20, 32'h0, "abort_lw20", 32'h11223344, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
